divider_arbiter: RTL

Sequencer and two-channel round-robin arbiter for one shared multi-cycle unsigned divider. It accepts divide requests from two requesters with a valid/ready handshake. It launches the divider with a one-cycle start pulse and holds the operands stable until the divider's finish. It then returns quotient and remainder to the owning requester. It sits between the execute-stage requesters and the single divider instance.

---
 rtl/divarb_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/divider_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/divarb_pkg.sv
// -----------------------------------------------------------------------------
// divarb_pkg
// Shared constants for the divider arbiter: FSM state encoding, default
// datapath width and timeout, and channel identifiers.
// -----------------------------------------------------------------------------
package divarb_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 40;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester combinational round-robin arbiter.
// Ports:
//   req_i   [1:0]  request vector (bit n = channel n)
//   last_i         channel served most recently (0 = ch0, 1 = ch1)
//   grant_o [1:0]  one-hot grant, zero when nobody requests
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // Single requester always wins; on contention the channel not served last wins.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/divider_arbiter.sv
// -----------------------------------------------------------------------------
// divider_arbiter
// Sequencer and two-channel round-robin arbiter in front of one shared
// multi-cycle unsigned divider.
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready/a/b     request handshake and operands (N = 0,1)
//   respN_valid/q/r/err      one-cycle result strobe with quotient,
//                            remainder and timeout flag
//   div_start, div_a, div_b  divider launch pulse and held operands
//   div_finish, div_q, div_r divider completion and results
//   busy                     high whenever the controller is not idle
// Optional feature: DIVARB_ZERO_BYPASS_EN answers b==0 requests directly
// (q = all ones, r = a) without using the divider.
// -----------------------------------------------------------------------------
module divider_arbiter
  import divarb_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_q,
  output logic [WIDTH-1:0] resp0_r,
  output logic             resp0_err,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_q,
  output logic [WIDTH-1:0] resp1_r,
  output logic             resp1_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_finish,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             busy
);

  localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [1:0]       grant;
  logic             in_idle;
  logic             hs;
  logic             sel1;
  logic [WIDTH-1:0] a_sel, b_sel;

  rr_arbiter2 u_rr (
    .req_i   ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign in_idle    = (state_q == ST_IDLE);
  assign req0_ready = in_idle & grant[0];
  assign req1_ready = in_idle & grant[1];
  assign hs         = req0_ready | req1_ready;
  assign sel1       = grant[1];
  assign a_sel      = sel1 ? req1_a : req0_a;
  assign b_sel      = sel1 ? req1_b : req0_b;

  // Next-state and datapath capture for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          owner_d = sel1 ? CH1 : CH0;
          a_d     = a_sel;
          b_d     = b_sel;
          err_d   = 1'b0;
`ifdef DIVARB_ZERO_BYPASS_EN
          if (b_sel == '0) begin
            q_d     = '1;
            r_d     = a_sel;
            state_d = ST_RESP;
          end else begin
            state_d = ST_START;
          end
`else
          state_d = ST_START;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_ARM;
      // A finish still showing from the previous operation is ignored here.
      ST_ARM: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_finish) begin
          q_d     = div_q;
          r_d     = div_r;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          q_d     = '0;
          r_d     = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset returns to IDLE with ch1 marked as last served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= CH1;
      owner_q <= CH0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured operands feed the divider directly, so they stay stable
  // regardless of what the requesters do after the handshake.
  assign div_start = (state_q == ST_START);
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign busy      = ~in_idle;

  assign resp0_valid = (state_q == ST_RESP) & (owner_q == CH0);
  assign resp1_valid = (state_q == ST_RESP) & (owner_q == CH1);
  assign resp0_q     = resp0_valid ? q_q : '0;
  assign resp0_r     = resp0_valid ? r_q : '0;
  assign resp0_err   = resp0_valid & err_q;
  assign resp1_q     = resp1_valid ? q_q : '0;
  assign resp1_r     = resp1_valid ? r_q : '0;
  assign resp1_err   = resp1_valid & err_q;

endmodule
